keypad_scanner: RTL



---
 rtl/keypad_pkg.sv | 10 +
 rtl/keypad_sync.sv | 15 +
 rtl/keypad_scanner.sv | 102 ++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, column reset pattern and row priority encoder for keypad_scanner
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
  localparam logic [3:0] COL_INIT = 4'b1110;
  function automatic logic [2:0] row_pri(input logic [3:0] rs_n);
    row_pri = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (!rs_n[i]) row_pri = {1'b1, 2'(i)};
  endfunction
endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 2-FF synchronizer for active-low keypad rows, idles at all-ones (no key)
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  // two flops in series; reset to released-rows value
  always_ff @(posedge clk)
    if (reset) {q, meta} <= '1;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad scan, debounce and key report; KEY_REPEAT_EN adds auto-repeat while held
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEB_STEPS    = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int TW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEB_STEPS + 1);
  logic [TW-1:0] timer;
  logic          step_end;
  logic [3:0]    rs_n;
  state_t        state, state_nx;
  logic [1:0]    lat_row, lat_col, col_idx;
  logic [2:0]    hit;
  logic [DW-1:0] deb_cnt, deb_nx, deb_inc;
  logic          lat_low, deb_full, latch, accept, done, adv, rep_fire;
  keypad_sync #(.W(4)) u_sync (.clk(clk), .reset(reset), .d(row_n), .q(rs_n));
  assign step_end = timer == TW'(SCAN_DIV - 1);
  assign hit      = row_pri(rs_n);
  assign col_idx  = {~col_n[3] | ~col_n[2], ~col_n[3] | ~col_n[1]};
  assign lat_low  = ~rs_n[lat_row];
  assign deb_inc  = deb_cnt + 1'b1;
  assign deb_full = deb_inc == DW'(DEB_STEPS);
  // free-running step timer; rows are judged on the last clock of each step
  always_ff @(posedge clk)
    if (reset) timer <= '0;
    else timer <= step_end ? '0 : timer + 1'b1;
  // state register
  always_ff @(posedge clk)
    if (reset) state <= SCAN;
    else state <= state_nx;
  // next state, evaluated only at step boundaries
  always_comb begin
    state_nx = state;
    if (step_end)
      case (state)
        SCAN:     state_nx = hit[2] ? DEBOUNCE : SCAN;
        DEBOUNCE: state_nx = !lat_low ? SCAN : deb_full ? HELD : DEBOUNCE;
        HELD:     state_nx = lat_low ? HELD : RELEASE;
        RELEASE:  state_nx = lat_low ? HELD : deb_full ? SCAN : RELEASE;
        default:  state_nx = SCAN;
      endcase
  end
  // control strobes and debounce count for the coming step
  always_comb begin
    latch  = step_end && state == SCAN && hit[2];
    accept = step_end && state == DEBOUNCE && lat_low && deb_full;
    done   = step_end && state == RELEASE && !lat_low && deb_full;
    adv    = step_end && ((state == SCAN && !hit[2]) || (state == DEBOUNCE && !lat_low) || done);
    deb_nx = deb_cnt;
    if (step_end)
      case (state)
        SCAN:     deb_nx = hit[2] ? DW'(1) : '0;
        DEBOUNCE: deb_nx = lat_low && !deb_full ? deb_inc : '0;
        HELD:     deb_nx = lat_low ? '0 : DW'(1);
        RELEASE:  deb_nx = !lat_low && !deb_full ? deb_inc : '0;
        default:  deb_nx = '0;
      endcase
  end
`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  logic [RW-1:0] rep_cnt, rep_inc;
  assign rep_inc  = rep_cnt + 1'b1;
  assign rep_fire = step_end && state == HELD && lat_low && rep_inc == RW'(REPEAT_DELAY);
  // held-step counter; after each repeat it rewinds so the next one lands REPEAT_RATE steps later
  always_ff @(posedge clk)
    if (reset || state != HELD) rep_cnt <= '0;
    else if (step_end) rep_cnt <= rep_fire ? RW'(REPEAT_DELAY - REPEAT_RATE) : rep_inc;
`else
  assign rep_fire = 1'b0 & |{REPEAT_DELAY, REPEAT_RATE};
`endif
  // datapath: column shifter, latched key position, debounce count and outputs
  always_ff @(posedge clk)
    if (reset) begin
      col_n     <= COL_INIT;
      lat_row   <= '0;
      lat_col   <= '0;
      deb_cnt   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      deb_cnt   <= deb_nx;
      key_valid <= (accept | rep_fire) & ~key_valid;
      if (latch) {lat_row, lat_col} <= {hit[1:0], col_idx};
      if (adv) col_n <= {col_n[2:0], col_n[3]};
      if (accept) key_code <= {lat_row, lat_col};
      if (accept) key_held <= 1'b1;
      else if (done) key_held <= 1'b0;
    end
endmodule
